vector_bram_writer: RTL and testbench

Parametrised successor to the vector-dump block. Snapshots a packed vector of VLEN words and streams it, one word per clock, into a BRAM write port starting at address 0, with optional tail fill up to DEPTH. A pass starts on an explicit start pulse, a periodic refresh tick, or (optionally) a detected vector change. Drives port B of a true-dual-port BRAM; the PS reads port A, which is outside this block.

---
 rtl/vector_bram_writer_pkg.sv | 20 ++
 rtl/vbw_refresh_timer.sv | 37 +++
 rtl/vector_bram_writer.sv | 155 +++++++++++++++
 tb/tb_vector_bram_writer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_bram_writer_pkg.sv
// Shared types and helpers for vector_bram_writer.
// Contents: FSM state enum, default tail-fill pattern, and the last-address
// helper that sizes one pass.
package vector_bram_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam logic [31:0] DEFAULT_FILL_WORD = 32'hDEAD_FEED;

  // Address of the final word written in a pass.
  function automatic int unsigned last_addr(input int unsigned vlen,
                                            input int unsigned depth,
                                            input bit          fill_tail);
    return fill_tail ? (depth - 1) : (vlen - 1);
  endfunction

endpackage

// File: rtl/vbw_refresh_timer.sv
// Free-running refresh timer for vector_bram_writer.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   o_tick     : high for one cycle whenever the counter is all ones;
//                constant 0 when REFRESH_LOG2 = 0
// The counter wraps and is never cleared except by reset.
module vbw_refresh_timer #(
  parameter int unsigned REFRESH_LOG2 = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  // Keep at least one counter bit so the disabled build stays legal.
  localparam int unsigned CW = (REFRESH_LOG2 == 0) ? 1 : REFRESH_LOG2;
  localparam logic [CW-1:0] ALL_ONES = '1;
  localparam logic [CW-1:0] PRE_TICK = ALL_ONES - CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered one step early so it is high exactly while the
  // counter holds all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= (REFRESH_LOG2 != 0) && (r_cnt == PRE_TICK);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vector_bram_writer.sv
// Snapshots a packed vector of VLEN words and streams it, one word per
// clock, into BRAM port B starting at address 0, optionally filling the
// remaining addresses up to DEPTH-1 with FILL_WORD.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   vec         : packed input, word k = vec[DWIDTH*k +: DWIDTH]
//   start       : single-cycle pass request
//   bram_addr   : port-B word address
//   bram_din    : port-B write data
//   bram_we     : port-B write enable
//   busy        : high while a pass is writing
//   done        : high on the cycle the last word of a pass is on the port
//   pass_count  : completed passes, wrapping
// Optional macro VECTOR_BRAM_WRITER_CHANGE_DETECT_EN: when defined, any
// difference between vec and the held snapshot also requests a pass.
module vector_bram_writer
  import vector_bram_writer_pkg::*;
#(
  parameter int unsigned VLEN         = 1,
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned AWIDTH       = 11,
  parameter int unsigned DEPTH        = 2048,
  parameter bit          FILL_TAIL    = 1'b1,
  parameter logic [31:0] FILL_WORD    = DEFAULT_FILL_WORD,
  parameter int unsigned REFRESH_LOG2 = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DWIDTH*VLEN-1:0] vec,
  input  logic                   start,
  output logic [AWIDTH-1:0]      bram_addr,
  output logic [DWIDTH-1:0]      bram_din,
  output logic                   bram_we,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pass_count
);

  localparam int unsigned        LAST   = last_addr(VLEN, DEPTH, FILL_TAIL);
  localparam logic [AWIDTH-1:0]  LAST_A = AWIDTH'(LAST);
  localparam logic [DWIDTH-1:0]  FILL_D = DWIDTH'(FILL_WORD);

  if (!((VLEN >= 1) && (VLEN <= DEPTH) &&
        (64'(DEPTH) <= (64'd1 << AWIDTH)))) begin : g_bad_params
    $error("vector_bram_writer: need 1 <= VLEN <= DEPTH <= 2**AWIDTH");
  end

  state_e                 r_state;
  logic [DWIDTH*VLEN-1:0] r_snapshot;
  logic [AWIDTH-1:0]      r_addr;
  logic [DWIDTH-1:0]      r_din;
  logic                   r_we;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_pending;
  logic [15:0]            r_pass_count;

  logic                   w_tick;
  logic                   w_change;
  logic                   w_request;
  logic [AWIDTH-1:0]      w_next_addr;
  logic [DWIDTH-1:0]      w_next_word;

  vbw_refresh_timer #(
    .REFRESH_LOG2 (REFRESH_LOG2)
  ) u_refresh (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

`ifdef VECTOR_BRAM_WRITER_CHANGE_DETECT_EN
  assign w_change = (vec != r_snapshot);
`else
  assign w_change = 1'b0;
`endif

  // New requests arriving now; pending is added separately in IDLE.
  assign w_request   = start | w_tick | w_change;
  assign w_next_addr = r_addr + AWIDTH'(1);

  // Word-select mux: snapshot words first, fill pattern beyond VLEN.
  always_comb begin
    w_next_word = FILL_D;
    for (int unsigned k = 0; k < VLEN; k++) begin
      if (w_next_addr == AWIDTH'(k)) begin
        w_next_word = r_snapshot[DWIDTH*k +: DWIDTH];
      end
    end
  end

  // Pass sequencer; done is registered one cycle ahead so it coincides
  // with the final word being on the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_snapshot   <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pending    <= 1'b0;
      r_pass_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_request || r_pending) begin
            r_snapshot <= vec;
            r_addr     <= '0;
            r_din      <= vec[DWIDTH-1:0];
            r_we       <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= (LAST_A == '0);
            r_pending  <= 1'b0;
            r_state    <= WRITE;
          end else begin
            r_we <= 1'b0;
          end
        end
        WRITE: begin
          // Requests during a pass merge into a single follow-up pass.
          if (w_request) begin
            r_pending <= 1'b1;
          end
          if (r_addr == LAST_A) begin
            r_we         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass_count <= r_pass_count + 16'd1;
            r_state      <= IDLE;
          end else begin
            r_addr <= w_next_addr;
            r_din  <= w_next_word;
            r_done <= (w_next_addr == LAST_A);
          end
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bram_addr  = r_addr;
  assign bram_din   = r_din;
  assign bram_we    = r_we;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass_count = r_pass_count;

endmodule

// File: tb/tb_vector_bram_writer.sv
// Self-checking bench for vector_bram_writer. Three instances share clk,
// reset and vec: A (tail fill, no refresh), B (no tail fill, no refresh),
// C (tail fill, refresh every 16 cycles). A cycle-level reference model,
// written in terms of pass position and pending requests, predicts every
// output of every instance.
module tb_vector_bram_writer;

  localparam logic [31:0] FEED = 32'hDEAD_FEED;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] vec;
  logic        start_q [3];

  logic [2:0]  addr_o [3];
  logic [31:0] din_o  [3];
  logic        we_o   [3];
  logic        busy_o [3];
  logic        done_o [3];
  logic [15:0] pc_o   [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vector_bram_writer #(
    .VLEN(3), .DWIDTH(32), .AWIDTH(3), .DEPTH(8), .FILL_TAIL(1'b1),
    .FILL_WORD(32'hDEAD_FEED), .REFRESH_LOG2(0)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .vec(vec), .start(start_q[0]),
    .bram_addr(addr_o[0]), .bram_din(din_o[0]), .bram_we(we_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .pass_count(pc_o[0])
  );

  vector_bram_writer #(
    .VLEN(3), .DWIDTH(32), .AWIDTH(3), .DEPTH(8), .FILL_TAIL(1'b0),
    .FILL_WORD(32'hDEAD_FEED), .REFRESH_LOG2(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .vec(vec), .start(start_q[1]),
    .bram_addr(addr_o[1]), .bram_din(din_o[1]), .bram_we(we_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .pass_count(pc_o[1])
  );

  vector_bram_writer #(
    .VLEN(3), .DWIDTH(32), .AWIDTH(3), .DEPTH(8), .FILL_TAIL(1'b1),
    .FILL_WORD(32'hDEAD_FEED), .REFRESH_LOG2(4)
  ) u_c (
    .clk(clk), .rst_n(rst_n), .vec(vec), .start(start_q[2]),
    .bram_addr(addr_o[2]), .bram_din(din_o[2]), .bram_we(we_o[2]),
    .busy(busy_o[2]), .done(done_o[2]), .pass_count(pc_o[2])
  );

  // ---------------- reference model ----------------
  int          m_last [3] = '{7, 2, 7};
  int          m_per  [3] = '{0, 0, 16};
  int          m_pos  [3];          // word index on the port, -1 when idle
  bit          m_pend [3];
  logic [95:0] m_snap [3];
  logic [2:0]  m_addr [3];
  logic [31:0] m_din  [3];
  logic [15:0] m_cnt  [3];
  int          m_cyc;               // edges since reset release

  function automatic logic [31:0] m_word(int i, int k);
    if (k < 3) return m_snap[i][32*k +: 32];
    return FEED;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_pos[i] = -1; m_pend[i] = 1'b0; m_snap[i] = '0;
        m_addr[i] = '0; m_din[i] = '0; m_cnt[i] = '0;
      end
      m_cyc = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit req;
        req = start_q[i];
        if (m_per[i] != 0) req = req | ((m_cyc % m_per[i]) == m_per[i] - 1);
`ifdef VECTOR_BRAM_WRITER_CHANGE_DETECT_EN
        req = req | (vec != m_snap[i]);
`endif
        if (m_pos[i] < 0) begin
          if (req || m_pend[i]) begin
            m_pos[i] = 0; m_snap[i] = vec; m_pend[i] = 1'b0;
            m_addr[i] = 3'd0; m_din[i] = vec[31:0];
          end
        end else begin
          if (req) m_pend[i] = 1'b1;
          if (m_pos[i] == m_last[i]) begin
            m_pos[i] = -1;
            m_cnt[i] = m_cnt[i] + 16'd1;
          end else begin
            m_pos[i]  = m_pos[i] + 1;
            m_addr[i] = 3'(m_pos[i]);
            m_din[i]  = m_word(i, m_pos[i]);
          end
        end
      end
      m_cyc = m_cyc + 1;
    end
  end

  // {we, busy, done, addr, din, pass_count}
  function automatic logic [53:0] exp_v(int i);
    return {m_pos[i] >= 0, m_pos[i] >= 0, m_pos[i] == m_last[i],
            m_addr[i], m_din[i], m_cnt[i]};
  endfunction

  function automatic logic [53:0] obs_v(int i);
    return {we_o[i], busy_o[i], done_o[i], addr_o[i], din_o[i], pc_o[i]};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    vec   = '0;
    for (int i = 0; i < 3; i++) start_q[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs_v(i) !== 54'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want 0", i, obs_v(i));
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_pass_shape();
    logic [31:0] da[$];
    logic [31:0] db[$];
    logic [2:0]  aa[$];
    int          n_done = 0;
    logic [2:0]  done_addr = '0;
    @(negedge clk);
    vec = {32'h3, 32'h2, 32'h1};
    start_q[0] = 1'b1; start_q[1] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start_q[0] = 1'b0; start_q[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL pass_shape dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      if (we_o[0]) begin
        da.push_back(din_o[0]); aa.push_back(addr_o[0]);
        if (done_o[0]) begin n_done++; done_addr = addr_o[0]; end
      end
      if (we_o[1]) db.push_back(din_o[1]);
    end
    n_checks++;
    if (da.size() != 8) begin
      n_fail++; $display("FAIL shape_len_a: got %0d want 8", da.size());
    end
    for (int k = 0; k < da.size() && k < 8; k++) begin
      n_checks++;
      if (da[k] !== ((k < 3) ? 32'(k + 1) : FEED) || aa[k] !== 3'(k)) begin
        n_fail++;
        $display("FAIL shape_word_a k%0d: got %h@%0d want %h@%0d", k, da[k], aa[k],
                 (k < 3) ? 32'(k + 1) : FEED, k);
      end
    end
    n_checks++;
    if (db.size() != 3 || db[0] !== 32'h1 || db[1] !== 32'h2 || db[2] !== 32'h3) begin
      n_fail++; $display("FAIL shape_b: got %0d words want 1,2,3", db.size());
    end
    n_checks++;
    if (n_done != 1 || done_addr !== 3'd7) begin
      n_fail++; $display("FAIL shape_done_a: got %0d at %0d want 1 at 7", n_done, done_addr);
    end
    n_checks++;
    if (pc_o[0] !== 16'd1 || pc_o[1] !== 16'd1) begin
      n_fail++; $display("FAIL shape_count: got %0d/%0d want 1/1", pc_o[0], pc_o[1]);
    end
  endtask

  task automatic test_fill_tail_off();
    int         n_we = 0;
    int         n_done = 0;
    logic [2:0] done_addr = '0;
    @(negedge clk);
    start_q[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      start_q[1] = 1'b0;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL fill_tail_off dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      if (we_o[1]) begin
        n_checks++;
        if (addr_o[1] !== 3'(n_we)) begin
          n_fail++; $display("FAIL tail_off_addr: got %0d want %0d", addr_o[1], n_we);
        end
        n_we++;
        if (done_o[1]) begin n_done++; done_addr = addr_o[1]; end
      end
    end
    n_checks++;
    if (n_we != 3 || n_done != 1 || done_addr !== 3'd2 || pc_o[1] !== 16'd2) begin
      n_fail++;
      $display("FAIL tail_off_shape: got we=%0d done=%0d@%0d pc=%0d want 3,1@2,2",
               n_we, n_done, done_addr, pc_o[1]);
    end
  endtask

  task automatic test_snapshot_pending();
    logic [31:0] want_din;
    logic        want_we;
    @(negedge clk);
    start_q[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL snap_pend dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      want_we  = (c <= 8) || (c >= 10 && c <= 17);
      want_din = (c <= 3) ? 32'(c) : (c >= 10 && c <= 12) ? 32'h9 : FEED;
      n_checks++;
      if (we_o[0] !== want_we || (want_we && din_o[0] !== want_din)) begin
        n_fail++;
        $display("FAIL snap_pend_seq c%0d: got we=%b din=%h want we=%b din=%h",
                 c, we_o[0], din_o[0], want_we, want_din);
      end
      start_q[0] = (c == 2) || (c == 4);
      if (c == 2) vec = {32'h9, 32'h9, 32'h9};
    end
    n_checks++;
    if (pc_o[0] !== 16'd3) begin
      n_fail++; $display("FAIL snap_pend_count: got %0d want 3", pc_o[0]);
    end
  endtask

  task automatic test_refresh();
    int rises[$];
    bit prev_we = we_o[2];
    for (int c = 0; c < 84; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL refresh dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      if (c >= 20 && we_o[2] && !prev_we) rises.push_back(c);
      prev_we = we_o[2];
    end
    n_checks++;
    if (rises.size() != 4) begin
      n_fail++; $display("FAIL refresh_passes: got %0d want 4", rises.size());
    end
    for (int k = 1; k < rises.size(); k++) begin
      n_checks++;
      if (rises[k] - rises[k-1] != 16) begin
        n_fail++; $display("FAIL refresh_period: got %0d want 16", rises[k] - rises[k-1]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start_q[0] = 1'b1;
    @(negedge clk);
    start_q[0] = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (we_o[0] !== 1'b1 || addr_o[0] !== 3'd4) begin
      n_fail++; $display("FAIL areset_pre: got we=%b addr=%0d want 1,4", we_o[0], addr_o[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (we_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || addr_o[0] !== 3'd0 ||
        done_o[0] !== 1'b0 || pc_o[0] !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_now: got we=%b busy=%b addr=%0d done=%b pc=%0d want 0,0,0,0,0",
               we_o[0], busy_o[0], addr_o[0], done_o[0], pc_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL areset_after dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL random dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      for (int i = 0; i < 3; i++) start_q[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) vec = {$urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 3; i++) start_q[i] = 1'b0;
  endtask

`ifdef VECTOR_BRAM_WRITER_CHANGE_DETECT_EN
  task automatic test_change_detect();
    int          first_c = -1;
    logic [31:0] first_din = '0;
    @(negedge clk);
    rst_n = 1'b0;
    vec   = 96'h5;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (obs_v(i) !== exp_v(i)) begin
          n_fail++;
          $display("FAIL change dut%0d c%0d: got %h want %h", i, c, obs_v(i), exp_v(i));
        end
      end
      if (we_o[0] && first_c < 0) begin first_c = c; first_din = din_o[0]; end
    end
    n_checks++;
    if (first_c != 1 || first_din !== 32'h5 || pc_o[0] !== 16'd1 || pc_o[1] !== 16'd1) begin
      n_fail++;
      $display("FAIL change_auto: got c%0d din=%h pc=%0d/%0d want c1 din=5 pc=1/1",
               first_c, first_din, pc_o[0], pc_o[1]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_shape();
    test_fill_tail_off();
    test_snapshot_pending();
    test_refresh();
    test_async_reset();
    test_random();
`ifdef VECTOR_BRAM_WRITER_CHANGE_DETECT_EN
    test_change_detect();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
